// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-master memory arbiter: FSM encoding and
// counter width.
package mem_arbiter_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Two-way round-robin choice: a lone requester wins, a tie goes to the
// master that did not own the last grant.
module rr_pick (
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant,
  output logic       valid
);

  // NOTE: every output is assigned on every path, so no latch is inferred.
  always_comb begin
    valid = |req;
    grant = (req == 2'b11) ? ~last : req[1];
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates two masters onto one synchronous single-port memory; each grant
// runs a fixed four-cycle IDLE/ACCESS/CAPTURE/DONE sequence.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int MEM_ADDR_SIZE = 12
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     m0_req,
  input  logic                     m0_wen,
  input  logic [MEM_ADDR_SIZE-1:0] m0_addr,
  input  logic [WIDTH-1:0]         m0_wdata,
  output logic                     m0_ack,
  output logic [WIDTH-1:0]         m0_rdata,
  input  logic                     m1_req,
  input  logic                     m1_wen,
  input  logic [MEM_ADDR_SIZE-1:0] m1_addr,
  input  logic [WIDTH-1:0]         m1_wdata,
  output logic                     m1_ack,
  output logic [WIDTH-1:0]         m1_rdata,
  output logic [MEM_ADDR_SIZE-1:0] mem_addr,
  output logic [WIDTH-1:0]         mem_wdata,
  output logic                     mem_wen,
  input  logic [WIDTH-1:0]         mem_rdata,
  output logic                     owner,
  output logic [CNT_W-1:0]         cnt0,
  output logic [CNT_W-1:0]         cnt1
);

  state_t state;
  logic   op_wen;
  logic   pick_grant;
  logic   pick_valid;

  rr_pick u_rr_pick (
    .req   ({m1_req, m0_req}),
    .last  (owner),
    .grant (pick_grant),
    .valid (pick_valid)
  );

  // NOTE: all state is updated with non-blocking assignments so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (!reset) begin
      // NOTE: the block holds no memory arrays, so every register is reset.
      state     <= IDLE;
      op_wen    <= 1'b0;
      owner     <= 1'b1;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wen   <= 1'b0;
      m0_ack    <= 1'b0;
      m1_ack    <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
      cnt0      <= '0;
      cnt1      <= '0;
    end else begin
      m0_ack  <= 1'b0;
      m1_ack  <= 1'b0;
      mem_wen <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            owner     <= pick_grant;
            mem_addr  <= pick_grant ? m1_addr  : m0_addr;
            mem_wdata <= pick_grant ? m1_wdata : m0_wdata;
            op_wen    <= pick_grant ? m1_wen   : m0_wen;
            mem_wen   <= pick_grant ? m1_wen   : m0_wen;
            state     <= ACCESS;
          end
        end
        ACCESS: state <= CAPTURE;
        CAPTURE: begin
          // Memory answers the ACCESS-cycle address during this cycle.
          if (!op_wen) begin
            if (owner) m1_rdata <= mem_rdata;
            else       m0_rdata <= mem_rdata;
          end
          state <= DONE;
        end
        DONE: begin
          if (owner) begin
            m1_ack <= 1'b1;
            cnt1   <= cnt1 + CNT_W'(1);
          end else begin
            m0_ack <= 1'b1;
            cnt0   <= cnt0 + CNT_W'(1);
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: transaction-level reference model checked
// every cycle, plus literal expectations for each scenario.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int W = 32;
  localparam int A = 12;

  logic         clk = 1'b0;
  logic         reset;
  logic         m0_req, m1_req, m0_wen, m1_wen;
  logic [A-1:0] m0_addr, m1_addr, mem_addr;
  logic [W-1:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, mem_wdata, mem_rdata;
  logic         m0_ack, m1_ack, mem_wen, owner;
  logic [CNT_W-1:0] cnt0, cnt1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.WIDTH(W), .MEM_ADDR_SIZE(A)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_wen(m0_wen), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_wen(m1_wen), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen),
    .mem_rdata(mem_rdata), .owner(owner), .cnt0(cnt0), .cnt1(cnt1)
  );

  // Synchronous single-port memory; unwritten words read as zero.
  logic [W-1:0] env_mem [1<<A];
  bit           env_vld [1<<A];
  always @(posedge clk) begin
    if (mem_wen) begin
      env_mem[mem_addr] <= mem_wdata;
      env_vld[mem_addr] <= 1'b1;
    end
    mem_rdata <= env_vld[mem_addr] ? env_mem[mem_addr] : '0;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each grant is a timestamped transaction; outputs follow
  // from how many edges have passed since the grant edge.
  logic         e_owner, e_wen;
  logic [1:0]   e_ack;
  logic [A-1:0] e_addr;
  logic [W-1:0] e_wdata;
  logic [W-1:0] e_rdata [2];
  logic [CNT_W-1:0] e_cnt [2];
  logic [W-1:0] mm [int];
  logic         busy = 1'b0;
  logic         t_own, t_wen;
  logic [A-1:0] t_addr;
  logic [W-1:0] t_wdata;
  int           cyc = 0;
  int           t0  = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
    e_ack = 2'b00;
    e_wen = 1'b0;
    if (!reset) begin
      busy = 1'b0; e_owner = 1'b1; e_addr = '0; e_wdata = '0;
      e_rdata[0] = '0; e_rdata[1] = '0; e_cnt[0] = '0; e_cnt[1] = '0;
    end else if (busy) begin
      case (cyc - t0)
        1: if (t_wen) mm[int'(t_addr)] = t_wdata;
        2: if (!t_wen) e_rdata[t_own] = mm.exists(int'(t_addr)) ? mm[int'(t_addr)] : '0;
        default: begin
          e_ack[t_own] = 1'b1;
          e_cnt[t_own] = e_cnt[t_own] + 16'd1;
          busy = 1'b0;
        end
      endcase
    end else if (m0_req || m1_req) begin
      t_own   = (m0_req && m1_req) ? ~e_owner : m1_req;
      t_wen   = t_own ? m1_wen   : m0_wen;
      t_addr  = t_own ? m1_addr  : m0_addr;
      t_wdata = t_own ? m1_wdata : m0_wdata;
      e_owner = t_own; e_addr = t_addr; e_wdata = t_wdata; e_wen = t_wen;
      busy = 1'b1;
      t0   = cyc;
    end
  end

  bit cmp_en = 1'b0;
  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      check("owner",     owner,     e_owner);
      check("mem_addr",  mem_addr,  e_addr);
      check("mem_wdata", mem_wdata, e_wdata);
      check("mem_wen",   mem_wen,   e_wen);
      check("m0_ack",    m0_ack,    e_ack[0]);
      check("m1_ack",    m1_ack,    e_ack[1]);
      check("m0_rdata",  m0_rdata,  e_rdata[0]);
      check("m1_rdata",  m1_rdata,  e_rdata[1]);
      check("cnt0",      cnt0,      e_cnt[0]);
      check("cnt1",      cnt1,      e_cnt[1]);
      check("ack_excl",  m0_ack & m1_ack, 1'b0);
    end
  end

  task automatic drive(input bit m, input bit r, input bit wen, input logic [A-1:0] a,
                       input logic [W-1:0] d);
    if (m) begin m1_req = r; m1_wen = wen; m1_addr = a; m1_wdata = d; end
    else   begin m0_req = r; m0_wen = wen; m0_addr = a; m0_wdata = d; end
  endtask

  // One access from master m; req dropped on ack, or early at drop_at.
  task automatic do_access(input bit m, input bit wen, input logic [A-1:0] a,
                           input logic [W-1:0] d, input int drop_at,
                           output int lat, output int wen_n, output logic [A-1:0] wen_a);
    bit got = 1'b0;
    lat = 0; wen_n = 0; wen_a = '0;
    drive(m, 1'b1, wen, a, d);
    for (int i = 1; i <= 12 && !got; i++) begin
      @(negedge clk);
      if (mem_wen === 1'b1) begin wen_n++; wen_a = mem_addr; end
      if (i == drop_at) drive(m, 1'b0, wen, a, d);
      if ((m ? m1_ack : m0_ack) === 1'b1) begin
        got = 1'b1;
        lat = i;
        drive(m, 1'b0, wen, a, d);
      end
    end
    check("ack_seen", got, 1'b1);
  endtask

  task automatic wait_ack(output int who, output int lat);
    who = -1; lat = 0;
    for (int i = 1; i <= 12 && who < 0; i++) begin
      @(negedge clk);
      if (m0_ack === 1'b1)      begin who = 0; lat = i; end
      else if (m1_ack === 1'b1) begin who = 1; lat = i; end
    end
    check("ack_timeout", who >= 0, 1'b1);
  endtask

  int lat, wen_n, who, n_ack, k;
  logic [A-1:0] wen_a;
  int seq [4];
  int at  [4];

  initial begin
    reset = 1'b0;
    drive(0, 0, 0, '0, '0);
    drive(1, 0, 0, '0, '0);
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    check("rst_owner", owner, 1'b1);
    check("rst_wen",   mem_wen, 1'b0);
    check("rst_cnt0",  cnt0, 16'h0000);
    check("rst_rdata", m0_rdata, 32'h0);
    reset = 1'b1;
    @(negedge clk);

    // m0 write, then m1 reads it back
    do_access(0, 1, 12'h005, 32'hDEADBEEF, 0, lat, wen_n, wen_a);
    check("wr_latency", lat, 4);
    check("wr_wen_cycles", wen_n, 1);
    check("wr_wen_addr", wen_a, 12'h005);
    check("wr_cnt0", cnt0, 16'd1);
    do_access(1, 0, 12'h005, 32'h0, 0, lat, wen_n, wen_a);
    check("rd_latency", lat, 4);
    check("rd_no_wen", wen_n, 0);
    check("rd_m1_rdata", m1_rdata, 32'hDEADBEEF);
    check("rd_m0_rdata", m0_rdata, 32'h0);
    check("rd_cnt1", cnt1, 16'd1);

    // Simultaneous held requests alternate
    drive(0, 1, 1, 12'h010, 32'h11111111);
    drive(1, 1, 0, 12'h010, 32'h0);
    n_ack = 0;
    for (int i = 1; i <= 40 && n_ack < 4; i++) begin
      @(negedge clk);
      if (m0_ack === 1'b1 || m1_ack === 1'b1) begin
        seq[n_ack] = (m1_ack === 1'b1) ? 1 : 0;
        at[n_ack]  = i;
        n_ack++;
      end
    end
    drive(0, 0, 1, 12'h010, 32'h11111111);
    drive(1, 0, 0, 12'h010, 32'h0);
    check("tie_acks", n_ack, 4);
    check("tie_first_at", at[0], 4);
    for (int i = 0; i < 4; i++) begin
      check("tie_order", seq[i], i % 2);
      if (i > 0) check("tie_spacing", at[i] - at[i-1], 4);
    end
    check("tie_m1_rdata", m1_rdata, 32'h11111111);
    check("tie_cnt0", cnt0, 16'd3);
    check("tie_cnt1", cnt1, 16'd3);

    // m1 drops req during ACCESS; access still completes
    do_access(1, 0, 12'h005, 32'h0, 1, lat, wen_n, wen_a);
    check("drop_latency", lat, 4);
    check("drop_cnt1", cnt1, 16'd4);
    check("drop_m1_rdata", m1_rdata, 32'hDEADBEEF);
    k = 0;
    repeat (6) begin
      @(negedge clk);
      if (m1_ack === 1'b1) k++;
    end
    check("drop_single_ack", k, 0);

    // Reset in CAPTURE aborts the access
    drive(0, 1, 1, 12'h020, 32'hCAFEF00D);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    drive(0, 0, 1, 12'h020, 32'hCAFEF00D);
    @(negedge clk);
    check("abort_ack", m0_ack, 1'b0);
    check("abort_owner", owner, 1'b1);
    check("abort_addr", mem_addr, 12'h000);
    check("abort_wdata", mem_wdata, 32'h0);
    check("abort_wen", mem_wen, 1'b0);
    check("abort_cnt0", cnt0, 16'd0);
    check("abort_cnt1", cnt1, 16'd0);
    check("abort_rdata", m1_rdata, 32'h0);
    reset = 1'b1;
    k = 0;
    repeat (6) begin
      @(negedge clk);
      if (m0_ack === 1'b1 || m1_ack === 1'b1) k++;
    end
    check("abort_no_ack", k, 0);

    // After reset m0 wins the first tie; the aborted write already hit memory
    drive(0, 1, 0, 12'h020, 32'h0);
    drive(1, 1, 0, 12'h020, 32'h0);
    wait_ack(who, lat);
    drive(0, 0, 0, 12'h020, 32'h0);
    check("post_rst_first", who, 0);
    check("post_rst_lat", lat, 4);
    wait_ack(who, lat);
    drive(1, 0, 0, 12'h020, 32'h0);
    check("post_rst_second", who, 1);
    check("post_rst_lat2", lat, 4);
    check("post_rst_m0_rdata", m0_rdata, 32'hCAFEF00D);
    check("post_rst_m1_rdata", m1_rdata, 32'hCAFEF00D);

    // Counter wrap: preload cnt0 near the top instead of 65535 accesses
    force dut.cnt0 = 16'hFFFE;
    e_cnt[0] = 16'hFFFE;
    @(negedge clk);
    release dut.cnt0;
    @(negedge clk);
    do_access(0, 0, 12'h005, 32'h0, 0, lat, wen_n, wen_a);
    check("wrap_ffff", cnt0, 16'hFFFF);
    do_access(0, 0, 12'h005, 32'h0, 0, lat, wen_n, wen_a);
    check("wrap_zero", cnt0, 16'h0000);
    check("wrap_cnt1", cnt1, 16'd1);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
